// File: rtl/vip_pkg.sv
// Shared definitions for the vip frame sequencer:
// FSM state encodings, frame_cnt phase codes and width defaults.
package vip_pkg;

   localparam int DIGIT_W_DEF = 24;
   localparam int MATCH_W     = 4;
   localparam int TMO_W       = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROJ = 2'd1,
      ST_REC  = 2'd2
   } state_e;

   localparam logic [1:0] FC_IDLE = 2'd0;
   localparam logic [1:0] FC_PROJ = 2'd1;
   localparam logic [1:0] FC_REC  = 2'd2;

   function automatic logic [1:0] fc_of(state_e s);
      logic [1:0] fc;
      fc = FC_IDLE;
      unique case (s)
         ST_PROJ: fc = FC_PROJ;
         ST_REC:  fc = FC_REC;
         default: fc = FC_IDLE;
      endcase
      return fc;
   endfunction

endpackage

// File: rtl/vip_stable_filter.sv
// N-sample stability filter: a recognised digit is published only after
// STABLE_N consecutive identical results that differ from the current digit.
module vip_stable_filter
   import vip_pkg::*;
#(
   parameter int DIGIT_W  = DIGIT_W_DEF,
   parameter int STABLE_N = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_i,
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               digit_upd_o
);

   localparam logic [MATCH_W-1:0] N_M = MATCH_W'(STABLE_N);

   logic [DIGIT_W-1:0] cand_q, cand_d;
   logic [DIGIT_W-1:0] digit_q, digit_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               upd_q, upd_d;

   always_comb begin
      cand_d  = cand_q;
      match_d = match_q;
      digit_d = digit_q;
      upd_d   = 1'b0;
      if (valid_i) begin
         if (digit_i == cand_q) begin
            if (match_q < N_M) match_d = match_q + 1'b1;
         end else begin
            cand_d  = digit_i;
            match_d = MATCH_W'(1);
         end
         // publish only on a run that just became stable and changes the value
         if (match_d == N_M && cand_d != digit_q) begin
            digit_d = cand_d;
            upd_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q  <= '0;
         match_q <= '0;
         digit_q <= '0;
         upd_q   <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         match_q <= match_d;
         digit_q <= digit_d;
         upd_q   <= upd_d;
      end
   end

   assign digit_o     = digit_q;
   assign digit_upd_o = upd_q;

endmodule

// File: rtl/vip_frame_sched.sv
// Frame sequencer: alternates projection and recognition frames on vsync
// edges, with projection/recognition timeouts and a stability filter.
module vip_frame_sched
   import vip_pkg::*;
#(
   parameter int DIGIT_W  = DIGIT_W_DEF,
   parameter int STABLE_N = 3,
   parameter int TMO_FRM  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               frame_vsync,
   input  logic               proj_done,
   input  logic               rec_valid,
   input  logic [DIGIT_W-1:0] rec_digit,
   output logic [1:0]         frame_cnt,
   output logic               proj_en,
   output logic               rec_en,
   output logic [DIGIT_W-1:0] digit,
   output logic               digit_upd,
   output logic               err
);

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_FRM);

   state_e           state_q, state_d;
   logic             vs_q;
   logic             sof;
   logic             pdone_q, pdone_d;
   logic             seen_q, seen_d;
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
   logic             err_q, err_d;
   logic [1:0]       fc_q;
   logic             proj_en_q, rec_en_q;
   logic             rec_ok;

   assign sof     = frame_vsync & ~vs_q;
   assign rec_ok  = rec_valid & (state_q == ST_REC);
   assign tmo_inc = tmo_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pdone_d = pdone_q;
      seen_d  = seen_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;
      if (state_q == ST_PROJ && proj_done) pdone_d = 1'b1;
      if (rec_ok) seen_d = 1'b1;
      if (sof) begin
         // frame-scoped flags restart at every frame boundary
         pdone_d = 1'b0;
         seen_d  = 1'b0;
         if (!enable) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end else begin
            unique case (state_q)
               ST_IDLE: state_d = ST_PROJ;
               ST_PROJ: begin
                  if (pdone_q | proj_done) state_d = ST_REC;
                  else err_d = 1'b1;
               end
               ST_REC: begin
                  if (seen_q | rec_ok) begin
                     state_d = ST_PROJ;
                     tmo_d   = '0;
                  end else if (tmo_inc >= TMO_LIM) begin
                     state_d = ST_PROJ;
                     tmo_d   = '0;
                     err_d   = 1'b1;
                  end else begin
                     tmo_d = tmo_inc;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         vs_q      <= 1'b0;
         pdone_q   <= 1'b0;
         seen_q    <= 1'b0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         fc_q      <= FC_IDLE;
         proj_en_q <= 1'b0;
         rec_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         vs_q      <= frame_vsync;
         pdone_q   <= pdone_d;
         seen_q    <= seen_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         fc_q      <= fc_of(state_d);
         proj_en_q <= (state_d == ST_PROJ);
         rec_en_q  <= (state_d == ST_REC);
      end
   end

   vip_stable_filter #(
      .DIGIT_W  (DIGIT_W),
      .STABLE_N (STABLE_N)
   ) u_filt (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (rec_ok),
      .digit_i     (rec_digit),
      .digit_o     (digit),
      .digit_upd_o (digit_upd)
   );

   assign frame_cnt = fc_q;
   assign proj_en   = proj_en_q;
   assign rec_en    = rec_en_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vip_frame_sched.sv
// Directed bench for vip_frame_sched: frame sequencing, stability
// filter, timeouts, enable drop and asynchronous reset.
module tb_vip_frame_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        frame_vsync;
   logic        proj_done;
   logic        rec_valid;
   logic [23:0] rec_digit;
   logic [1:0]  frame_cnt;
   logic        proj_en;
   logic        rec_en;
   logic [23:0] digit;
   logic        digit_upd;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   vip_frame_sched #(
      .DIGIT_W  (24),
      .STABLE_N (3),
      .TMO_FRM  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_vsync (frame_vsync),
      .proj_done   (proj_done),
      .rec_valid   (rec_valid),
      .rec_digit   (rec_digit),
      .frame_cnt   (frame_cnt),
      .proj_en     (proj_en),
      .rec_en      (rec_en),
      .digit       (digit),
      .digit_upd   (digit_upd),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof();
      frame_vsync = 1'b1;
      tick();
      frame_vsync = 1'b0;
   endtask

   task automatic pulse_pd();
      proj_done = 1'b1;
      tick();
      proj_done = 1'b0;
   endtask

   task automatic pulse_rv(input logic [23:0] d);
      rec_digit = d;
      rec_valid = 1'b1;
      tick();
      rec_valid = 1'b0;
   endtask

   task automatic outs(input string tag, input logic [1:0] fc,
                       input logic pe, input logic re);
      chk({tag, ".fc"}, 32'(frame_cnt), 32'(fc));
      chk({tag, ".pe"}, 32'(proj_en), 32'(pe));
      chk({tag, ".re"}, 32'(rec_en), 32'(re));
   endtask

   // REC -> PROJ (with proj_done) -> REC, then one result
   task automatic rec_round(input string tag, input logic [23:0] d);
      tick();
      sof();
      outs({tag, ".p"}, 2'd1, 1'b1, 1'b0);
      tick();
      pulse_pd();
      tick();
      sof();
      outs({tag, ".r"}, 2'd2, 1'b0, 1'b1);
      tick();
      pulse_rv(d);
   endtask

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      frame_vsync = 1'b0;
      proj_done   = 1'b0;
      rec_valid   = 1'b0;
      rec_digit   = '0;
      tick();
      tick();
      outs("rst", 2'd0, 1'b0, 1'b0);
      chk("rst.digit", 32'(digit), 32'h0);
      chk("rst.upd", 32'(digit_upd), 32'h0);
      chk("rst.err", 32'(err), 32'h0);
      rst_n  = 1'b1;
      enable = 1'b1;
      tick();
      outs("idle", 2'd0, 1'b0, 1'b0);

      // frame sequencing
      sof();
      outs("f1", 2'd1, 1'b1, 1'b0);
      tick();
      pulse_pd();
      tick();
      sof();
      outs("f2", 2'd2, 1'b0, 1'b1);
      chk("f2.err", 32'(err), 32'h0);
      tick();
      pulse_rv(24'h001234);
      chk("s1.upd", 32'(digit_upd), 32'h0);

      // stability filter: third identical result publishes
      rec_round("s2", 24'h001234);
      chk("s2.upd", 32'(digit_upd), 32'h0);
      chk("s2.dig", 32'(digit), 32'h0);
      rec_round("s3", 24'h001234);
      chk("s3.upd", 32'(digit_upd), 32'h1);
      chk("s3.dig", 32'(digit), 32'h001234);
      tick();
      chk("s3.upd1", 32'(digit_upd), 32'h0);

      // mismatch restarts the candidate
      rec_round("m1", 24'h005678);
      chk("m1.upd", 32'(digit_upd), 32'h0);
      rec_round("m2", 24'h005678);
      chk("m2.upd", 32'(digit_upd), 32'h0);
      rec_round("m3", 24'h009abc);
      chk("m3.upd", 32'(digit_upd), 32'h0);
      rec_round("m4", 24'h005678);
      chk("m4.upd", 32'(digit_upd), 32'h0);
      chk("m4.dig", 32'(digit), 32'h001234);

      // projection timeout
      tick();
      sof();
      outs("pt0", 2'd1, 1'b1, 1'b0);
      tick();
      sof();
      chk("pt.err", 32'(err), 32'h1);
      outs("pt1", 2'd1, 1'b1, 1'b0);
      tick();
      chk("pt.err1", 32'(err), 32'h0);

      // recognition timeout after two empty frames
      pulse_pd();
      tick();
      sof();
      outs("rt0", 2'd2, 1'b0, 1'b1);
      tick();
      sof();
      chk("rt1.err", 32'(err), 32'h0);
      outs("rt1", 2'd2, 1'b0, 1'b1);
      tick();
      sof();
      chk("rt2.err", 32'(err), 32'h1);
      outs("rt2", 2'd1, 1'b1, 1'b0);

      // events coincident with sof belong to the ending frame
      tick();
      proj_done = 1'b1;
      sof();
      proj_done = 1'b0;
      outs("cp", 2'd2, 1'b0, 1'b1);
      tick();
      rec_digit = 24'h005678;
      rec_valid = 1'b1;
      sof();
      rec_valid = 1'b0;
      outs("cr", 2'd1, 1'b1, 1'b0);
      chk("cr.err", 32'(err), 32'h0);
      chk("cr.upd", 32'(digit_upd), 32'h0);

      // rec_valid outside REC is ignored (would otherwise publish 5678)
      tick();
      pulse_rv(24'h005678);
      chk("ign.upd", 32'(digit_upd), 32'h0);
      chk("ign.dig", 32'(digit), 32'h001234);

      // enable drop mid-REC
      pulse_pd();
      tick();
      sof();
      outs("en0", 2'd2, 1'b0, 1'b1);
      enable = 1'b0;
      tick();
      outs("en1", 2'd2, 1'b0, 1'b1);
      sof();
      outs("en2", 2'd0, 1'b0, 1'b0);
      chk("en2.dig", 32'(digit), 32'h001234);
      enable = 1'b1;
      tick();
      outs("en3", 2'd0, 1'b0, 1'b0);
      sof();
      outs("en4", 2'd1, 1'b1, 1'b0);

      // asynchronous reset mid-frame
      tick();
      rst_n = 1'b0;
      #1;
      outs("ar", 2'd0, 1'b0, 1'b0);
      chk("ar.dig", 32'(digit), 32'h0);
      chk("ar.err", 32'(err), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      outs("ar1", 2'd0, 1'b0, 1'b0);
      sof();
      outs("ar2", 2'd1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
